uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
- Memory-mapped UART transmit front-end. Sits between the CPU data bus and the tx_uart serializer.
- CPU byte writes to the TX register are queued in a FIFO and drained to tx_uart one byte at a time, so the CPU no longer stalls for a full character time per byte.
- Also answers LSR reads with buffer-aware status.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
TX_ADDR, 32'h1000_0000, byte address of TX data register (write)
LSR_ADDR, 32'h1000_0005, byte address of line status register (read)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
valid  input  1  CPU bus request
addr  input  32  CPU byte address
wstrb  input  4  write strobes; any bit set = write
wdata  input  32  write data; byte [7:0] used
rdata  output  32  read data; valid only while ready=1
ready  output  1  one-cycle completion pulse
is_valid  output  1  addr equals TX_ADDR or LSR_ADDR (combinational decode for SoC mux)
rx_data_avail  input  1  from rx_uart; mirrored into LSR bit 0
tx_start  output  1  one-cycle start pulse to tx_uart
tx_data  output  8  byte for tx_uart; held stable from tx_start until tx_done
tx_done  input  1  tx_uart ready pulse: character finished
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release) values:
  - FIFO pointers = 0, level = 0.
  - ready, tx_start = 0; tx_data = 0; rdata = 0.
  - Drain FSM = IDLE.
- Bus acceptance: a request is accepted in cycle N when valid && is_valid && !ready, with these qualifiers:
  - TX write: additionally requires FIFO not full. While full, the request is held off and ready stays 0 (back-pressure stall).
  - TX read: accepted; returns 0; no push.
  - LSR write: accepted; ignored.
- Acceptance timing: ready=1 in cycle N+1 for exactly one cycle, then 0. Minimum latency 1 cycle.
- Push: occurs at the acceptance edge of a TX write; stores wdata[7:0] at the write pointer.
- LSR read data = {16'b0, lsr, 8'b0}, sampled at acceptance:
  - lsr[7] = 0
  - lsr[6] (TEMT) = FIFO empty && FSM==IDLE
  - lsr[5] (THRE) = FIFO not full
  - lsr[4:1] = 0
  - lsr[0] = rx_data_avail
- Drain FSM:
  - IDLE: if FIFO non-empty, pop the head into tx_data, assert tx_start for one cycle, go to BUSY.
  - BUSY: wait for tx_done; on tx_done go to IDLE.
  - Next start may occur in the cycle after tx_done (IDLE evaluates FIFO non-empty), so back-to-back characters carry one idle cycle.
  - tx_done received in IDLE is ignored.
- FIFO rules:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full when level==DEPTH; empty when level==0.
  - Simultaneous push and pop in the same cycle: both performed, level unchanged. This is legal even when full: the pop frees a slot, so a write held off by full is accepted in the cycle a pop occurs.
  - Pop is never taken while empty; push is never taken while full without a same-cycle pop.
- Reset mid-operation:
  - Queued bytes are discarded and the FSM returns to IDLE.
  - A pending bus request is dropped (no ready); the CPU is reset together with this block.
- Unmatched addresses: no response, is_valid=0, ready=0.

Test Plan:
- Reset, then LSR read -> ready pulse one cycle after valid; rdata = 32'h0000_6000 (TEMT=1, THRE=1, DR=0); level=0.
- Write 8'h41 to TX_ADDR with tx_done tied 0 -> ready next cycle; tx_start pulses once with tx_data=8'h41; LSR read returns 32'h0000_2000 (TEMT=0).
- Write 17 bytes 8'h00..8'h10 (DEPTH=16) with tx_done held low after the first start:
  - 8'h00 is popped into BUSY; 8'h01..8'h10 fill the FIFO to level=16.
  - The 18th write, 8'h11, is stalled with ready=0.
  - A single tx_done pulse pops 8'h01, and the 18th write then completes within 2 cycles.
- Drain with tx_done pulsed 10 cycles after each tx_start -> tx_data sequence exactly 8'h00..8'h11 in order; exactly 18 tx_start pulses; final LSR = 32'h0000_6000.
- Push and pop in the same cycle at level=DEPTH -> level stays DEPTH; no byte lost or duplicated across pointer wrap (scoreboard compare).
- Assert rst while BUSY with level=5 -> level=0, tx_start=0, ready=0 immediately (asynchronously). After release, no tx_start occurs until a new TX write; rx_data_avail=1 then reads back as LSR bit 0 = 1.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// UART transmit front-end: CPU byte writes are queued in a FIFO and handed to
// tx_uart one character at a time; LSR reads report buffer-aware status.
//
// state | meaning
// IDLE  | no character in flight; pops the FIFO head when non-empty
// BUSY  | tx_uart is serializing tx_data; waits for tx_done
module uart_tx_buffer #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] TX_ADDR  = 32'h1000_0000,
  parameter logic [31:0] LSR_ADDR = 32'h1000_0005
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [31:0]            addr,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   is_valid,
  input  logic                   rx_data_avail,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          hit_tx;
  logic          hit_lsr;
  logic          is_write;
  logic          accept;
  logic          push;
  logic          pop;
  logic [7:0]    lsr;
  logic [31:0]   rdata_nxt;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign hit_tx   = (addr == TX_ADDR);
  assign hit_lsr  = (addr == LSR_ADDR);
  assign is_valid = hit_tx | hit_lsr;
  assign is_write = |wstrb;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));

  // A full FIFO still takes a TX write in the cycle the drain FSM pops.
  assign accept = valid && is_valid && !ready &&
                  !(hit_tx && is_write && fifo_full && !pop);
  assign push   = accept && hit_tx && is_write;

  assign lsr = {1'b0, fifo_empty && (state == IDLE), !fifo_full, 4'b0, rx_data_avail};

  always_comb begin
    rdata_nxt = '0;
    if (hit_lsr && !is_write) rdata_nxt = {16'b0, lsr, 8'b0};
  end

  // drain FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = BUSY;
      BUSY:    if (tx_done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // drain FSM: outputs
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  // tx_data is loaded only on a pop, so it holds until the next character
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= accept;
      rdata <= accept ? rdata_nxt : '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: decode vectors, fill/stall/drain, reset mid-flight,
// and randomized traffic against a byte-queue model of the transmit path.
module tb_uart_tx_buffer;
  localparam int          DEPTH    = 16;
  localparam int          LW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] TX_ADDR  = 32'h1000_0000;
  localparam logic [31:0] LSR_ADDR = 32'h1000_0005;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [31:0]   addr = '0;
  logic [3:0]    wstrb = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic          is_valid;
  logic          rx_data_avail = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done = 1'b0;
  logic [LW-1:0] level;

  int tests = 0;
  int fails = 0;

  logic [7:0] acc_q[$];
  logic [7:0] tx_log[$];
  int lvl_err = 0;
  int ord_err = 0;
  int done_delay = 0;
  int done_cnt = 0;
  int done_req_n = 0;
  int done_ack_n = 0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        rx;
    logic        e_iv;
    logic        e_rdy;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .TX_ADDR(TX_ADDR), .LSR_ADDR(LSR_ADDR)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata), .ready(ready), .is_valid(is_valid), .rx_data_avail(rx_data_avail),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .level(level)
  );

  // tx_uart stand-in: tx_done after done_delay cycles (-1 picks 1..6), or on request
  initial forever begin
    @(negedge clk);
    tx_done = 1'b0;
    if (rst) done_cnt = 0;
    else if (done_req_n != done_ack_n) begin
      tx_done = 1'b1;
      done_ack_n = done_req_n;
    end else if (tx_start && done_delay != 0)
      done_cnt = (done_delay < 0) ? int'($urandom_range(1, 6)) : done_delay;
    else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
  end

  // model: occupancy = bytes accepted since reset minus bytes handed to tx_uart
  initial forever begin
    @(negedge clk);
    if (rst) tx_log.delete();
    else begin
      if (tx_start) begin
        if (tx_log.size() >= acc_q.size() || tx_data !== acc_q[tx_log.size()]) ord_err++;
        tx_log.push_back(tx_data);
      end
      if (int'(level) != acc_q.size() - tx_log.size()) lvl_err++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    rst = 1'b1;
    acc_q.delete();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int budget, output bit got, output int lat,
                     output logic [31:0] rd, output logic iv);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    got = 1'b0; lat = 0; rd = '0;
    #1;
    iv = is_valid;
    for (int i = 1; i <= budget && !got; i++) begin
      cyc();
      if (ready) begin
        got = 1'b1;
        lat = i;
        rd = rdata;
      end
    end
    valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    if (got && a == TX_ADDR && s != 4'h0) acc_q.push_back(d[7:0]);
    if (got) begin
      cyc();
      check("ready single-cycle", {31'b0, ready}, 32'h0);
    end
  endtask

  initial begin
    bit got;
    int lat;
    logic [31:0] rd;
    logic iv;
    logic [31:0] rnd;
    logic [31:0] a;

    tbl[0]  = '{LSR_ADDR,         4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_6000};
    tbl[1]  = '{LSR_ADDR,         4'h0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_6100};
    tbl[2]  = '{32'h1000_0004,    4'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{32'h1000_0001,    4'hF, 32'h55,        1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{TX_ADDR,          4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{LSR_ADDR,         4'h1, 32'hFF,        1'b0, 1'b1, 1'b1, 32'h0};
    tbl[6]  = '{LSR_ADDR,         4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_6000};
    tbl[7]  = '{TX_ADDR,          4'h1, 32'hDEAD_BE41, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[8]  = '{LSR_ADDR,         4'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_2000};
    tbl[9]  = '{TX_ADDR,          4'h8, 32'h0000_005A, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[10] = '{LSR_ADDR,         4'h0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_2100};

    // reset values
    done_delay = 0;
    do_reset();
    check("reset level", 32'(level), 32'h0);
    check("reset ready", {31'b0, ready}, 32'h0);
    check("reset tx_start", {31'b0, tx_start}, 32'h0);
    check("reset tx_data", {24'b0, tx_data}, 32'h0);
    check("reset rdata", rdata, 32'h0);

    // decode / response vectors, tx_done held low
    for (int i = 0; i < 11; i++) begin
      rx_data_avail = tbl[i].rx;
      bus(tbl[i].a, tbl[i].s, tbl[i].d, 4, got, lat, rd, iv);
      check($sformatf("vec%0d is_valid", i), {31'b0, iv}, {31'b0, tbl[i].e_iv});
      check($sformatf("vec%0d ready", i), {31'b0, got}, {31'b0, tbl[i].e_rdy});
      if (tbl[i].e_rdy) check($sformatf("vec%0d latency", i), lat, 1);
      if (tbl[i].e_rdy && tbl[i].s == 4'h0) check($sformatf("vec%0d rdata", i), rd, tbl[i].e_rd);
    end
    rx_data_avail = 1'b0;
    check("vec starts", tx_log.size(), 1);
    check("vec first byte", {24'b0, tx_log[0]}, 32'h41);
    check("vec level", 32'(level), 32'h1);

    // fill to full, stall, release by one tx_done, then drain
    do_reset();
    for (int b = 0; b < 17; b++) begin
      bus(TX_ADDR, 4'h1, 32'(b), 4, got, lat, rd, iv);
      check($sformatf("fill%0d latency", b), lat, 1);
    end
    check("full level", 32'(level), 32'(DEPTH));
    bus(LSR_ADDR, 4'h0, 32'h0, 4, got, lat, rd, iv);
    check("full lsr", rd, 32'h0);
    valid = 1'b1; addr = TX_ADDR; wstrb = 4'h1; wdata = 32'h11;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ready) got = 1'b1;
    end
    check("full stall ready", {31'b0, got}, 32'h0);
    done_req_n++;
    lat = 0;
    for (int i = 1; i <= 4 && !got; i++) begin
      cyc();
      if (ready) begin
        got = 1'b1;
        lat = i;
      end
    end
    valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    if (got) acc_q.push_back(8'h11);
    done_delay = 10;
    check("stall release", {31'b0, got}, 32'h1);
    check("stall release within 2", {31'b0, lat >= 1 && lat <= 2}, 32'h1);
    check("push+pop at full level", 32'(level), 32'(DEPTH));
    cyc();
    check("stall ready single-cycle", {31'b0, ready}, 32'h0);
    for (int i = 0; i < 600 && tx_log.size() < 18; i++) cyc();
    repeat (12) cyc();
    check("drain start count", tx_log.size(), 18);
    for (int i = 0; i < 18 && i < tx_log.size(); i++)
      check($sformatf("drain byte%0d", i), {24'b0, tx_log[i]}, 32'(i));
    bus(LSR_ADDR, 4'h0, 32'h0, 4, got, lat, rd, iv);
    check("drain final lsr", rd, 32'h0000_6000);
    check("drain level", 32'(level), 32'h0);

    // reset while BUSY with queued bytes and a live request
    done_delay = 0;
    do_reset();
    for (int b = 0; b < 6; b++) bus(TX_ADDR, 4'h1, 32'hA0 + 32'(b), 4, got, lat, rd, iv);
    check("pre-reset level", 32'(level), 32'h5);
    valid = 1'b1; addr = TX_ADDR; wstrb = 4'h1; wdata = 32'hA6;
    cyc();
    check("pre-reset ready", {31'b0, ready}, 32'h1);
    #1;
    rst = 1'b1;
    acc_q.delete();
    #1;
    check("async reset level", 32'(level), 32'h0);
    check("async reset tx_start", {31'b0, tx_start}, 32'h0);
    check("async reset ready", {31'b0, ready}, 32'h0);
    repeat (2) begin
      cyc();
      check("ready held in reset", {31'b0, ready}, 32'h0);
    end
    valid = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    rst = 1'b0;
    repeat (20) cyc();
    check("no start after reset", tx_log.size(), 0);
    rx_data_avail = 1'b1;
    bus(LSR_ADDR, 4'h0, 32'h0, 4, got, lat, rd, iv);
    check("post-reset lsr rx", rd, 32'h0000_6100);
    rx_data_avail = 1'b0;
    bus(TX_ADDR, 4'h2, 32'hB7, 4, got, lat, rd, iv);
    repeat (3) cyc();
    check("post-reset starts", tx_log.size(), 1);
    check("post-reset byte", {24'b0, tx_log[0]}, 32'hB7);

    // randomized traffic with random tx_uart character times
    done_delay = -1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          bus(TX_ADDR, 4'($urandom_range(1, 15)), rnd, 200, got, lat, rd, iv);
          check("rand tx write", {31'b0, got}, 32'h1);
        end
        6: begin
          bus(TX_ADDR, 4'h0, rnd, 4, got, lat, rd, iv);
          check("rand tx read", {31'b0, got}, 32'h1);
          check("rand tx read data", rd, 32'h0);
        end
        7: begin
          rx_data_avail = rnd[0];
          bus(LSR_ADDR, 4'h0, 32'h0, 4, got, lat, rd, iv);
          check("rand lsr read", rd & ~32'h0000_6000, {23'b0, rnd[0], 8'b0});
        end
        8: begin
          bus(LSR_ADDR, 4'($urandom_range(1, 15)), rnd, 4, got, lat, rd, iv);
          check("rand lsr write", {31'b0, got}, 32'h1);
        end
        default: begin
          a = $urandom;
          if (a == TX_ADDR || a == LSR_ADDR) a = a ^ 32'h8;
          bus(a, rnd[3:0], rnd, 3, got, lat, rd, iv);
          check("rand unmatched ready", {31'b0, got}, 32'h0);
          check("rand unmatched is_valid", {31'b0, iv}, 32'h0);
        end
      endcase
      if (rnd[31]) cyc();
    end
    rx_data_avail = 1'b0;
    for (int i = 0; i < 400 && tx_log.size() < acc_q.size(); i++) cyc();
    repeat (10) cyc();
    check("rand start count", tx_log.size(), acc_q.size());
    bus(LSR_ADDR, 4'h0, 32'h0, 4, got, lat, rd, iv);
    check("rand final lsr", rd, 32'h0000_6000);
    check("order errors", ord_err, 0);
    check("level errors", lvl_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
